// File: rtl/gin_pkg.sv
// gin_pkg: definitions shared by the GIN transmitter (gin_driver) and gin_bus.
//   GIN_TAG_LENGTH / GIN_BITWIDTH : default tag and data widths
//   gin_state_e                   : driver FSM states (IDLE, PROG, RUN)
//   gin_pkt_t                     : tagged packet at the default widths
package gin_pkg;

  localparam int unsigned GIN_TAG_LENGTH = 4;
  localparam int unsigned GIN_BITWIDTH   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROG = 2'd1,
    ST_RUN  = 2'd2
  } gin_state_e;

  typedef struct packed {
    logic [GIN_TAG_LENGTH-1:0] tag;
    logic [GIN_BITWIDTH-1:0]   data;
  } gin_pkt_t;

endpackage

// File: rtl/gin_fifo.sv
// gin_fifo: synchronous FIFO with full/empty flags, DEPTH a power of two.
//   clk, rstb      : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata    : write request/data; ignored when full
//   pop            : read request; ignored when empty
//   rdata          : head entry (valid while !empty)
//   full, empty    : occupancy flags, reflect the state before this edge
module gin_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/gin_driver.sv
// gin_driver: transmitter side of the global input network.
// Programs the multicast controllers' tag IDs through the scan chain, then
// issues buffered tagged beats, each only when every controller whose tag
// matches is ready. Unmatched packets are dropped.
//   clk, rstb          : clock, asynchronous active-low reset
//   cfg_start          : request to (re)program tags (ignored while programming)
//   cfg_tag_id         : tag for controller k at [k*TAG_LENGTH +: TAG_LENGTH]
//   cfg_done           : one-cycle pulse after the last scan shift
//   in_valid/in_ready  : upstream handshake; in_tag/in_data packet contents
//   program_en         : scan-shift enable to gin_bus (its `program` input;
//                        `program` is a SystemVerilog keyword)
//   scan_tag_in        : scan data, entry NUM_CONTROLLERS-1 first
//   controller_enable  : one-cycle beat strobe; tag/data_source beat contents
//   controller_ready   : per-controller ready from gin_bus
//   busy               : programming, or packets buffered
//   drop_count         : only with GIN_DRIVER_DROP_CNT_EN; saturating count of
//                        unmatched-tag drops, cleared by reset and cfg_start
module gin_driver
  import gin_pkg::*;
#(
  parameter int unsigned BITWIDTH        = GIN_BITWIDTH,
  parameter int unsigned TAG_LENGTH      = GIN_TAG_LENGTH,
  parameter int unsigned NUM_CONTROLLERS = 10,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  cfg_start,
  input  logic [TAG_LENGTH*NUM_CONTROLLERS-1:0] cfg_tag_id,
  output logic                                  cfg_done,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [TAG_LENGTH-1:0]                 in_tag,
  input  logic [BITWIDTH-1:0]                   in_data,
  output logic                                  program_en,
  output logic [TAG_LENGTH-1:0]                 scan_tag_in,
  output logic                                  controller_enable,
  output logic [TAG_LENGTH-1:0]                 tag,
  output logic [BITWIDTH-1:0]                   data_source,
  input  logic [NUM_CONTROLLERS-1:0]            controller_ready,
  output logic                                  busy
`ifdef GIN_DRIVER_DROP_CNT_EN
  ,
  output logic [7:0]                            drop_count
`endif
);

  localparam int unsigned CW = $clog2(NUM_CONTROLLERS + 1);

  gin_state_e               state_q;
  logic [CW-1:0]            cnt_q;
  logic [TAG_LENGTH-1:0]    shadow_q [NUM_CONTROLLERS];
  logic                     prog_q;
  logic [TAG_LENGTH-1:0]    scan_q;
  logic                     done_q;
  logic                     en_q;
  logic [TAG_LENGTH-1:0]    tag_q;
  logic [BITWIDTH-1:0]      data_q;

  logic [TAG_LENGTH+BITWIDTH-1:0] fifo_rdata;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic [TAG_LENGTH-1:0]    head_tag;
  logic [BITWIDTH-1:0]      head_data;
  logic [NUM_CONTROLLERS-1:0] match;
  logic                     cfg_accept;
  logic                     issue;
  logic                     drop;
  logic [TAG_LENGTH-1:0]    scan_sel;

  assign in_ready          = !fifo_full;
  assign push              = in_valid && in_ready;
  assign head_tag          = fifo_rdata[BITWIDTH +: TAG_LENGTH];
  assign head_data         = fifo_rdata[BITWIDTH-1:0];
  assign busy              = (state_q == ST_PROG) || !fifo_empty;
  assign program_en        = prog_q;
  assign scan_tag_in       = scan_q;
  assign cfg_done          = done_q;
  assign controller_enable = en_q;
  assign tag               = tag_q;
  assign data_source       = data_q;

  gin_fifo #(
    .WIDTH (TAG_LENGTH + BITWIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (push),
    .wdata ({in_tag, in_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    match = '0;
    for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
      match[k] = (shadow_q[k] == head_tag);
    end
    cfg_accept = cfg_start && (state_q != ST_PROG);
    // Decisions use the table in force before this edge, so a beat that
    // coincides with a re-programming request still goes out.
    issue = (state_q == ST_RUN) && !fifo_empty && (match != '0) &&
            ((controller_ready & match) == match);
    drop  = (state_q == ST_RUN) && !fifo_empty && (match == '0);
    pop   = issue || drop;
    // Shift order: entry NUM_CONTROLLERS-1 first so controller k ends with entry k.
    scan_sel = '0;
    for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
      if (32'(cnt_q) == NUM_CONTROLLERS - 1 - k) scan_sel = shadow_q[k];
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      prog_q  <= 1'b0;
      scan_q  <= '0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) shadow_q[k] <= '0;
    end else begin
      en_q   <= issue;
      done_q <= 1'b0;
      if (issue) begin
        tag_q  <= head_tag;
        data_q <= head_data;
      end
      if (cfg_accept) begin
        for (int unsigned k = 0; k < NUM_CONTROLLERS; k++) begin
          shadow_q[k] <= cfg_tag_id[k*TAG_LENGTH +: TAG_LENGTH];
        end
        state_q <= ST_PROG;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          ST_PROG: begin
            // NUM_CONTROLLERS shift cycles, then one cycle to signal completion.
            if (32'(cnt_q) < NUM_CONTROLLERS) begin
              prog_q <= 1'b1;
              scan_q <= scan_sel;
              cnt_q  <= cnt_q + CW'(1);
            end else begin
              prog_q  <= 1'b0;
              scan_q  <= '0;
              done_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef GIN_DRIVER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  assign drop_count = drop_cnt_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      drop_cnt_q <= '0;
    end else if (cfg_accept) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end
`endif

endmodule
